r_type_sequencer: RTL and testbench



---
 rtl/r_type_sequencer_pkg.sv | 29 ++
 rtl/r_type_sequencer_if.sv | 32 +++
 rtl/r_type_sequencer_decoder.sv | 30 +++
 rtl/r_type_sequencer.sv | 111 +++++++++++
 tb/tb_r_type_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/r_type_sequencer_pkg.sv
// Shared constants for the R-type control path: opcode/funct encodings,
// ALU_OP codes understood by ALU_32, and the sequencer FSM state encoding.
package r_type_sequencer_pkg;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_NOR    = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_e;

endpackage

// File: rtl/r_type_sequencer_if.sv
// Run control, instruction-memory port and datapath control bundle.
// master = sequencer side, slave = memory/datapath/run-initiator side.
interface r_type_sequencer_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_instr;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [N-1:0]      imem_rdata;
  logic [N-1:0]      instruction;
  logic [3:0]        ALU_OP;
  logic              RegWrite;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [7:0]        illegal_count;

  modport master (
    input  start, base_addr, num_instr, imem_rdata,
    output imem_en, imem_addr, instruction, ALU_OP, RegWrite,
           busy, done, illegal, illegal_count
  );

  modport slave (
    output start, base_addr, num_instr, imem_rdata,
    input  imem_en, imem_addr, instruction, ALU_OP, RegWrite,
           busy, done, illegal, illegal_count
  );
endinterface

// File: rtl/r_type_sequencer_decoder.sv
// Combinational R-type decoder: maps opcode/funct to an ALU_OP code and a
// legal flag. Unknown encodings decode to ALU_AND with legal deasserted.
module r_type_decoder
  import r_type_sequencer_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    alu_op_o = ALU_AND;
    legal_o  = 1'b0;
    if (opcode_i == OPC_RTYPE) begin
      legal_o = 1'b1;
      case (funct_i)
        FUNCT_ADD: alu_op_o = ALU_ADD;
        FUNCT_SUB: alu_op_o = ALU_SUB;
        FUNCT_AND: alu_op_o = ALU_AND;
        FUNCT_OR:  alu_op_o = ALU_OR;
        FUNCT_NOR: alu_op_o = ALU_NOR;
        FUNCT_SLT: alu_op_o = ALU_SLT;
        default:   legal_o  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/r_type_sequencer.sv
// R-type sequencer: fetches a run of instructions from synchronous memory and
// issues each to the datapath over FETCH/DECODE/EXEC (3 cycles per instruction).
module r_type_sequencer
  import r_type_sequencer_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  r_type_sequencer_if.master  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [7:0]        illegal_count_q, illegal_count_d;
  logic [N-1:0]      instruction_q, instruction_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              legal_q, legal_d;
  logic              we_q, we_d;

  logic [3:0]        dec_alu_op;
  logic              dec_legal;

  r_type_decoder u_decoder (
    .opcode_i (bus.imem_rdata[31:26]),
    .funct_i  (bus.imem_rdata[5:0]),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    remaining_d     = remaining_q;
    illegal_count_d = illegal_count_q;
    instruction_d   = instruction_q;
    alu_op_d        = alu_op_q;
    legal_d         = legal_q;
    we_d            = we_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_instr != '0) begin
            pc_d            = bus.base_addr;
            remaining_d     = bus.num_instr;
            illegal_count_d = 8'd0;
            state_d         = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Memory data is valid this cycle; register the decode so EXEC is glitch-free.
        instruction_d = bus.imem_rdata;
        alu_op_d      = dec_alu_op;
        legal_d       = dec_legal;
        we_d          = dec_legal && (bus.imem_rdata[15:11] != 5'd0);
        state_d       = S_EXEC;
      end
      S_EXEC: begin
        pc_d        = pc_q + ADDR_W'(1);
        remaining_d = remaining_q - (ADDR_W+1)'(1);
        if (!legal_q && (illegal_count_q != 8'hFF))
          illegal_count_d = illegal_count_q + 8'd1;
        state_d = (remaining_d == '0) ? S_DONE : S_FETCH;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      remaining_q     <= '0;
      illegal_count_q <= 8'd0;
      instruction_q   <= '0;
      alu_op_q        <= ALU_AND;
      legal_q         <= 1'b0;
      we_q            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q         <= state_d;
      pc_q            <= pc_d;
      remaining_q     <= remaining_d;
      illegal_count_q <= illegal_count_d;
      instruction_q   <= instruction_d;
      alu_op_q        <= alu_op_d;
      legal_q         <= legal_d;
      we_q            <= we_d;
    end
  end

  assign bus.imem_en       = (state_q == S_FETCH);
  assign bus.imem_addr     = pc_q;
  assign bus.instruction   = instruction_q;
  assign bus.ALU_OP        = alu_op_q;
  assign bus.RegWrite      = (state_q == S_EXEC) && we_q;
  assign bus.illegal       = (state_q == S_EXEC) && !legal_q;
  assign bus.busy          = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign bus.done          = (state_q == S_DONE);
  assign bus.illegal_count = illegal_count_q;

endmodule

// File: tb/tb_r_type_sequencer.sv
// Directed bench for r_type_sequencer: a synchronous memory model feeds
// hand-encoded words; per-cycle traces are compared against hand-computed values.
module tb_r_type_sequencer;

  localparam int N      = 32;
  localparam int ADDR_W = 8;
  localparam int MAXC   = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  r_type_sequencer_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  r_type_sequencer #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] mem [256];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trace index c = c-th negedge after the start edge.
  logic        en_tr   [MAXC];
  logic [7:0]  addr_tr [MAXC];
  logic [3:0]  op_tr   [MAXC];
  logic [31:0] ins_tr  [MAXC];
  logic        rw_tr   [MAXC];
  logic        ill_tr  [MAXC];
  logic        busy_tr [MAXC];
  int          done_at;

  task automatic do_run(input logic [7:0] base, input logic [8:0] num);
    int limit;
    limit = 3 * int'(num) + 6;
    for (int i = 0; i < MAXC; i++) begin
      en_tr[i] = 0; addr_tr[i] = 0; op_tr[i] = 0; ins_tr[i] = 0;
      rw_tr[i] = 0; ill_tr[i] = 0; busy_tr[i] = 0;
    end
    done_at = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.num_instr = num;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      en_tr[c]   = bus.imem_en;
      addr_tr[c] = bus.imem_addr;
      op_tr[c]   = bus.ALU_OP;
      ins_tr[c]  = bus.instruction;
      rw_tr[c]   = bus.RegWrite;
      ill_tr[c]  = bus.illegal;
      busy_tr[c] = bus.busy;
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
  endtask

  function automatic int count_rw();
    int n = 0;
    for (int i = 1; i < MAXC; i++) n += int'(rw_tr[i]);
    return n;
  endfunction

  function automatic int count_ill();
    int n = 0;
    for (int i = 1; i < MAXC; i++) n += int'(ill_tr[i]);
    return n;
  endfunction

  function automatic int count_en();
    int n = 0;
    for (int i = 1; i < MAXC; i++) n += int'(en_tr[i]);
    return n;
  endfunction

  function automatic int count_busy();
    int n = 0;
    for (int i = 1; i < MAXC; i++) n += int'(busy_tr[i]);
    return n;
  endfunction

  initial begin
    logic rw_seen, done_seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    // run 1: add / sub / and
    mem[8'h10] = 32'h00018020;
    mem[8'h11] = 32'h01284022;
    mem[8'h12] = 32'h00C79824;
    mem[8'h13] = 32'h01284020;
    // run 2: add, lw, funct 001000, add
    mem[8'h20] = 32'h00018020;
    mem[8'h21] = 32'h8C010000;
    mem[8'h22] = 32'h00000008;
    mem[8'h23] = 32'h01284020;
    // run 3: add with rd = 0
    mem[8'h30] = 32'h00020020;
    // wrap run: or / nor / slt
    mem[8'hFF] = 32'h00221825;
    mem[8'h00] = 32'h00221827;
    mem[8'h01] = 32'h0022182A;

    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_instr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instruction", bus.instruction, 32'h0);
    check("rst_alu_op", 32'(bus.ALU_OP), 32'h0);
    check("rst_ctrl", 32'({bus.imem_en, bus.RegWrite, bus.busy, bus.done, bus.illegal}), 32'h0);
    check("rst_ill_cnt", 32'(bus.illegal_count), 32'h0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    rst = 1'b0;

    // Three legal instructions: EXEC at trace 3, 6, 9; done at 3K+1 = 10.
    do_run(8'h10, 9'd3);
    check("r1_busy_fetch", 32'(busy_tr[1]), 32'h1);
    check("r1_addr0", 32'(addr_tr[1]), 32'h10);
    check("r1_op_add", 32'(op_tr[3]), 32'h2);
    check("r1_op_sub", 32'(op_tr[6]), 32'h6);
    check("r1_op_and", 32'(op_tr[9]), 32'h0);
    check("r1_rw_exec", 32'({rw_tr[3], rw_tr[6], rw_tr[9]}), 32'h7);
    check("r1_rw_count", 32'(count_rw()), 32'd3);
    check("r1_instr_last", ins_tr[9], 32'h00C79824);
    check("r1_done_at", 32'(done_at), 32'd10);
    check("r1_busy_count", 32'(count_busy()), 32'd9);

    // Illegal words sandwiched between two adds.
    do_run(8'h20, 9'd4);
    check("r2_ill_pulses", 32'({ill_tr[3], ill_tr[6], ill_tr[9], ill_tr[12]}), 32'b0110);
    check("r2_ill_total", 32'(count_ill()), 32'd2);
    check("r2_rw_pattern", 32'({rw_tr[3], rw_tr[6], rw_tr[9], rw_tr[12]}), 32'b1001);
    check("r2_op_illegal", 32'(op_tr[6]), 32'h0);
    check("r2_done_at", 32'(done_at), 32'd13);
    @(negedge clk);
    check("r2_ill_cnt_held", 32'(bus.illegal_count), 32'd2);

    // Destination R0: legal, no write, no illegal pulse; count cleared by new start.
    do_run(8'h30, 9'd1);
    check("r3_op_add", 32'(op_tr[3]), 32'h2);
    check("r3_rw", 32'(count_rw()), 32'd0);
    check("r3_illegal", 32'(count_ill()), 32'd0);
    check("r3_done_at", 32'(done_at), 32'd4);
    check("r3_ill_cnt_clr", 32'(bus.illegal_count), 32'd0);

    // Empty run.
    do_run(8'h40, 9'd0);
    check("r4_done_at", 32'(done_at), 32'd1);
    check("r4_no_fetch", 32'(count_en()), 32'd0);
    check("r4_no_busy", 32'(count_busy()), 32'd0);

    // Address wrap from 0xFF.
    do_run(8'hFF, 9'd3);
    check("r5_addr_seq", 32'({addr_tr[1], addr_tr[4], addr_tr[7]}), 32'hFF0001);
    check("r5_en_fetch", 32'({en_tr[1], en_tr[4], en_tr[7]}), 32'h7);
    check("r5_en_count", 32'(count_en()), 32'd3);
    check("r5_ops", 32'({op_tr[3], op_tr[6], op_tr[9]}), 32'h1C7);
    check("r5_done_at", 32'(done_at), 32'd10);

    // Reset during DECODE of the 2nd of 4 instructions.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 8'h10; bus.num_instr = 9'd4;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 4) check("r6_fetch2_addr", 32'({bus.imem_en, bus.imem_addr}), 32'h111);
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("r6_rst_ctrl", 32'({bus.imem_en, bus.RegWrite, bus.busy, bus.done, bus.illegal}), 32'h0);
    check("r6_rst_instr", bus.instruction, 32'h0);
    check("r6_rst_op", 32'(bus.ALU_OP), 32'h0);
    rw_seen = 1'b0; done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      rw_seen   = rw_seen | bus.RegWrite;
      done_seen = done_seen | bus.done;
    end
    check("r6_no_rw_after", 32'(rw_seen), 32'h0);
    check("r6_no_done_after", 32'(done_seen), 32'h0);
    do_run(8'h10, 9'd1);
    check("r6_rerun_op", 32'(op_tr[3]), 32'h2);
    check("r6_rerun_rw", 32'(rw_tr[3]), 32'h1);
    check("r6_rerun_done", 32'(done_at), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
